// File: rtl/seq_shifter_pkg.sv
// ---------------------------------------------------------------------------
// seq_shifter_pkg
//
// Shared types and helpers for the sequential shift unit.
//   shift_mode_t : operation encoding carried on the 2-bit mode port
//   state_t      : control FSM encoding (IDLE / SHIFT / DONE)
//   shamt_w()    : width of the shift-amount / step-counter field for a
//                  given operand width
// ---------------------------------------------------------------------------
package seq_shifter_pkg;

    typedef enum logic [1:0] {
        SLL = 2'b00,    // logical left, zero fill from the LSB
        SRL = 2'b01,    // logical right, zero fill from the MSB
        SRA = 2'b10,    // arithmetic right, sign fill from the MSB
        ROL = 2'b11     // rotate left when enabled, otherwise treated as SLL
    } shift_mode_t;

    typedef enum logic [1:0] {
        IDLE  = 2'b00,
        SHIFT = 2'b01,
        DONE  = 2'b10
    } state_t;

    // Width of a field able to hold any shift amount 0..width-1.
    function automatic int shamt_w(input int width);
        return (width < 2) ? 1 : $clog2(width);
    endfunction

endpackage : seq_shifter_pkg

// File: rtl/seq_shifter_shift_step.sv
// ---------------------------------------------------------------------------
// shift_step
//
// Purely combinational single-step shifter. Moves an n-bit value by a
// variable amount k (the caller guarantees 0 <= k <= STEP < n) in the
// direction selected by mode.
//
// Optional feature macro: SEQ_SHIFTER_ROTATE_EN
//   defined   : mode ROL rotates left (MSB bits re-enter at the LSB)
//   undefined : mode ROL falls into the SLL path; no rotate logic exists
//
// Ports
//   value   in   n       value to shift
//   k       in   KW      shift amount for this step
//   mode    in   2       shift_mode_t operation select
//   shifted out  n       shifted value
// ---------------------------------------------------------------------------
module shift_step
    import seq_shifter_pkg::*;
#(
    parameter int n  = 32,
    parameter int KW = 5
) (
    input  logic [n-1:0]  value,
    input  logic [KW-1:0] k,
    input  shift_mode_t   mode,
    output logic [n-1:0]  shifted
);

`ifdef SEQ_SHIFTER_ROTATE_EN
    // Shifting a doubled copy left and keeping the upper half yields
    // (value << k) | (value >> (n - k)) without a subtraction in the path.
    logic [2*n-1:0] rot_full;
    assign rot_full = {value, value} << k;
`endif

    always_comb begin
        shifted = value << k;
        case (mode)
            SLL:     shifted = value << k;
            SRL:     shifted = value >> k;
            // The sign bit of the working value is the original sign bit,
            // since every earlier SRA step replicated it.
            SRA:     shifted = $signed(value) >>> k;
`ifdef SEQ_SHIFTER_ROTATE_EN
            ROL:     shifted = rot_full[2*n-1:n];
`endif
            default: shifted = value << k;
        endcase
    end

endmodule : shift_step

// File: rtl/seq_shifter.sv
// ---------------------------------------------------------------------------
// seq_shifter
//
// Multi-cycle variable shift unit. A request (num, shamt, mode) is accepted
// on a start edge while the unit is idle; the working register is then
// shifted by up to STEP bits per clock until the whole amount has been
// consumed, after which done pulses for one cycle.
//
// Optional feature macro: SEQ_SHIFTER_ROTATE_EN (enables rotate-left on
// mode 2'b11; otherwise mode 2'b11 behaves as SLL).
//
// Parameters
//   n     operand / result width (n >= 2)
//   STEP  maximum bits shifted per clock (1 <= STEP <= n-1)
//
// Ports
//   clk     in   1             rising-edge clock
//   reset   in   1             synchronous active-high reset
//   start   in   1             request strobe, taken only in IDLE
//   num     in   n             operand
//   shamt   in   $clog2(n)     shift amount
//   mode    in   2             00 SLL, 01 SRL, 10 SRA, 11 ROL/SLL
//   busy    out  1             high while shifting
//   done    out  1             one-cycle completion pulse
//   result  out  n             working register; final from done onwards
// ---------------------------------------------------------------------------
module seq_shifter
    import seq_shifter_pkg::*;
#(
    parameter int n    = 32,
    parameter int STEP = 1
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 start,
    input  logic [n-1:0]         num,
    input  logic [$clog2(n)-1:0] shamt,
    input  logic [1:0]           mode,
    output logic                 busy,
    output logic                 done,
    output logic [n-1:0]         result
);

    localparam int SHAMT_W = shamt_w(n);

    // Legacy-compatible state constants mirroring the package enum.
    localparam logic [1:0] ST_IDLE  = IDLE;
    localparam logic [1:0] ST_SHIFT = SHIFT;
    localparam logic [1:0] ST_DONE  = DONE;

    localparam logic [SHAMT_W-1:0] STEP_K = SHAMT_W'(STEP);

    if (n < 2 || STEP < 1 || STEP > n - 1) begin : g_param_check
        $error("seq_shifter: illegal parameters n=%0d STEP=%0d", n, STEP);
    end

    logic [1:0]         state_reg, state_next;
    logic [n-1:0]       data_reg, data_next;
    logic [SHAMT_W-1:0] count_reg, count_next;
    shift_mode_t        mode_reg, mode_next;
    logic               busy_reg, done_reg;

    logic [SHAMT_W-1:0] step_k;
    logic [n-1:0]       data_stepped;

    // Bits moved this cycle: a full STEP, or whatever remains on the last
    // step. Because step_k never exceeds count_reg the counter cannot wrap.
    assign step_k = (count_reg > STEP_K) ? STEP_K : count_reg;

    shift_step #(
        .n  (n),
        .KW (SHAMT_W)
    ) u_shift_step (
        .value   (data_reg),
        .k       (step_k),
        .mode    (mode_reg),
        .shifted (data_stepped)
    );

    always_comb begin
        state_next = state_reg;
        data_next  = data_reg;
        count_next = count_reg;
        mode_next  = mode_reg;
        case (state_reg)
            ST_IDLE: begin
                if (start) begin
                    data_next  = num;
                    count_next = shamt;
                    mode_next  = shift_mode_t'(mode);
                    state_next = (shamt == '0) ? ST_DONE : ST_SHIFT;
                end
            end
            ST_SHIFT: begin
                data_next  = data_stepped;
                count_next = count_reg - step_k;
                if (count_reg == step_k) begin
                    state_next = ST_DONE;
                end
            end
            ST_DONE: begin
                // Any start seen here is dropped; requests are not queued.
                state_next = ST_IDLE;
            end
            default: begin
                state_next = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_reg <= ST_IDLE;
            data_reg  <= '0;
            count_reg <= '0;
            mode_reg  <= SLL;
            busy_reg  <= 1'b0;
            done_reg  <= 1'b0;
        end else begin
            state_reg <= state_next;
            data_reg  <= data_next;
            count_reg <= count_next;
            mode_reg  <= mode_next;
            // Flag registers track the state register exactly, so the
            // outputs are glitch-free decodes of the current state.
            busy_reg  <= (state_next == ST_SHIFT);
            done_reg  <= (state_next == ST_DONE);
        end
    end

    assign busy   = busy_reg;
    assign done   = done_reg;
    assign result = data_reg;

endmodule : seq_shifter

// File: tb/tb_seq_shifter.sv
// ---------------------------------------------------------------------------
// tb_seq_shifter
//
// Directed bench for seq_shifter. Two instances share the request inputs:
// u_dut_s1 (n=32, STEP=1) and u_dut_s4 (n=32, STEP=4); sel routes start to
// one of them and picks which outputs are observed.
// ---------------------------------------------------------------------------
module tb_seq_shifter;

    logic        clk;
    logic        reset;
    logic        start;
    logic [31:0] num;
    logic [4:0]  shamt;
    logic [1:0]  mode;
    logic        sel;

    logic        start_s1, start_s4;
    logic        busy_s1, busy_s4, done_s1, done_s4;
    logic [31:0] result_s1, result_s4;
    logic        busy_o, done_o;
    logic [31:0] result_o;

    int n_compared;
    int n_mismatched;

    assign start_s1 = start & ~sel;
    assign start_s4 = start & sel;
    assign busy_o   = sel ? busy_s4   : busy_s1;
    assign done_o   = sel ? done_s4   : done_s1;
    assign result_o = sel ? result_s4 : result_s1;

    seq_shifter #(.n(32), .STEP(1)) u_dut_s1 (
        .clk    (clk),
        .reset  (reset),
        .start  (start_s1),
        .num    (num),
        .shamt  (shamt),
        .mode   (mode),
        .busy   (busy_s1),
        .done   (done_s1),
        .result (result_s1)
    );

    seq_shifter #(.n(32), .STEP(4)) u_dut_s4 (
        .clk    (clk),
        .reset  (reset),
        .start  (start_s4),
        .num    (num),
        .shamt  (shamt),
        .mode   (mode),
        .busy   (busy_s4),
        .done   (done_s4),
        .result (result_s4)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_compared++;
        if (got !== exp) begin
            n_mismatched++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    // One request on the selected instance. Latency is counted in edges
    // starting with the accepting edge, so shamt=0 gives 1. When poke is
    // set, a conflicting start is pulsed while the unit is busy.
    task automatic do_op(input string tag, input bit use_s4,
                         input logic [31:0] a, input logic [4:0] s,
                         input logic [1:0] m, input logic [31:0] exp_r,
                         input int exp_lat, input bit poke);
        int lat;
        int busy_cnt;
        logic [31:0] final_r;
        @(negedge clk);
        sel   = use_s4;
        start = 1'b1;
        num   = a;
        shamt = s;
        mode  = m;
        @(posedge clk);
        #1;
        start = 1'b0;
        num   = $urandom;
        shamt = 5'($urandom_range(0, 31));
        mode  = 2'($urandom_range(0, 3));
        lat      = 1;
        busy_cnt = 0;
        while (!done_o && lat < 200) begin
            if (busy_o) busy_cnt++;
            if (poke && lat == 2) begin
                start = 1'b1;
                num   = 32'hFFFF_FFFF;
                shamt = 5'd1;
                mode  = 2'b01;
            end else begin
                start = 1'b0;
            end
            @(posedge clk);
            #1;
            lat++;
        end
        start   = 1'b0;
        final_r = result_o;
        check({tag, "_lat"},    32'(lat),      32'(exp_lat));
        check({tag, "_busy"},   32'(busy_cnt), 32'(exp_lat - 1));
        check({tag, "_result"}, final_r,       exp_r);
        @(posedge clk);
        #1;
        check({tag, "_pulse"},  32'(done_o),   32'd0);
        check({tag, "_hold"},   result_o,      exp_r);
        $display("op %-10s step=%0d mode=%0d num=0x%08h shamt=%0d -> result=0x%08h lat=%0d",
                 tag, use_s4 ? 4 : 1, m, a, s, final_r, lat);
    endtask

    initial begin
        logic [31:0] rol_exp;
        n_compared   = 0;
        n_mismatched = 0;
        reset = 1'b1;
        start = 1'b0;
        sel   = 1'b0;
        num   = '0;
        shamt = '0;
        mode  = '0;
        repeat (2) @(posedge clk);
        #1;
        check("rst_busy_s1",   32'(busy_s1),   32'd0);
        check("rst_done_s1",   32'(done_s1),   32'd0);
        check("rst_result_s1", result_s1,      32'd0);
        check("rst_busy_s4",   32'(busy_s4),   32'd0);
        check("rst_result_s4", result_s4,      32'd0);
        @(negedge clk);
        reset = 1'b0;

        // STEP=1 vectors
        do_op("sll5",     1'b0, 32'h0000_0001, 5'd5,  2'b00, 32'h0000_0020, 6,  1'b0);
        do_op("sll31",    1'b0, 32'hFFFF_FFFF, 5'd31, 2'b00, 32'h8000_0000, 32, 1'b0);
        do_op("srl4",     1'b0, 32'h8000_0000, 5'd4,  2'b01, 32'h0800_0000, 5,  1'b0);
        do_op("sra4",     1'b0, 32'h8000_0000, 5'd4,  2'b10, 32'hF800_0000, 5,  1'b0);
        do_op("sra3pos",  1'b0, 32'h4000_0000, 5'd3,  2'b10, 32'h0800_0000, 4,  1'b0);
        do_op("zero_sll", 1'b0, 32'h1234_5678, 5'd0,  2'b00, 32'h1234_5678, 1,  1'b0);
        do_op("zero_sra", 1'b0, 32'h1234_5678, 5'd0,  2'b10, 32'h1234_5678, 1,  1'b0);
        do_op("poke",     1'b0, 32'h0000_0001, 5'd5,  2'b00, 32'h0000_0020, 6,  1'b1);

`ifdef SEQ_SHIFTER_ROTATE_EN
        rol_exp = 32'h0000_0018;
`else
        rol_exp = 32'h0000_0010;
`endif
        do_op("mode11",   1'b0, 32'h8000_0001, 5'd4,  2'b11, rol_exp,       5,  1'b0);

        // STEP=4 vectors
        do_op("s4_srl5",  1'b1, 32'hF000_0000, 5'd5,  2'b01, 32'h0780_0000, 3,  1'b0);
        do_op("s4_sll31", 1'b1, 32'hFFFF_FFFF, 5'd31, 2'b00, 32'h8000_0000, 9,  1'b0);
        do_op("s4_sra8",  1'b1, 32'h8000_00F0, 5'd8,  2'b10, 32'hFF80_0000, 3,  1'b0);
        do_op("s4_mode11", 1'b1, 32'h8000_0001, 5'd4, 2'b11, rol_exp,       2,  1'b0);

        // Reset on the third SHIFT cycle of an SLL by 10.
        @(negedge clk);
        sel   = 1'b0;
        start = 1'b1;
        num   = 32'h0000_0001;
        shamt = 5'd10;
        mode  = 2'b00;
        @(posedge clk);
        #1;
        start = 1'b0;
        @(posedge clk);
        #1;
        @(posedge clk);
        #1;
        check("mid_busy", 32'(busy_s1), 32'd1);
        reset = 1'b1;
        @(posedge clk);
        #1;
        check("abort_busy",   32'(busy_s1), 32'd0);
        check("abort_done",   32'(done_s1), 32'd0);
        check("abort_result", result_s1,    32'd0);
        reset = 1'b0;
        do_op("after_rst", 1'b0, 32'h0000_0003, 5'd3, 2'b00, 32'h0000_0018, 4, 1'b0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
        $finish;
    end

endmodule : tb_seq_shifter
